// File: rtl/pkt_steer_fork_avlstrm.sv
// N-way packet-granular Avalon-ST fork: each packet is steered whole to the output
// named by in_channel on its SOP beat; out-of-range channels are dropped and counted.
module pkt_steer_fork_avlstrm #(
  parameter int WIDTH   = 512,
  parameter int EMPTY_W = 6,
  parameter int N_OUT   = 4,
  parameter int CHAN_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sop,
  input  logic                     in_eop,
  input  logic [EMPTY_W-1:0]       in_empty,
  input  logic [CHAN_W-1:0]        in_channel,
  output logic [N_OUT*WIDTH-1:0]   out_data,
  output logic [N_OUT-1:0]         out_valid,
  input  logic [N_OUT-1:0]         out_ready,
  output logic [N_OUT-1:0]         out_sop,
  output logic [N_OUT-1:0]         out_eop,
  output logic [N_OUT*EMPTY_W-1:0] out_empty,
  output logic [N_OUT*32-1:0]      stats_out_pkt,
  output logic [31:0]              stats_drop_pkt,
  output logic [31:0]              stats_err_beat
);

  localparam int                SEL_W    = $clog2(N_OUT);
  localparam logic [CHAN_W-1:0] N_OUT_CH = CHAN_W'(N_OUT);

  typedef enum logic [1:0] {S_IDLE, S_PASS, S_DROP} state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             chan_ok;
  logic [SEL_W-1:0] target;
  logic [N_OUT-1:0] slot_free;
  logic             in_hs;
  logic             fwd;
  logic [SEL_W-1:0] fwd_dest;
  logic             fwd_sop, fwd_eop;
  logic             drop_inc, err_inc;
  logic [31:0]      drop_cnt_q, err_cnt_q;

  assign chan_ok   = in_channel < N_OUT_CH;
  assign target    = in_channel[SEL_W-1:0];
  assign slot_free = ~out_valid | out_ready;
  assign in_hs     = in_valid & in_ready;
  assign fwd       = in_hs && ((state_q == S_PASS) || (state_q == S_IDLE && in_sop && chan_ok));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      S_IDLE: if (in_hs && in_sop) begin
        if (chan_ok) begin
          sel_d = target;
          if (!in_eop) state_d = S_PASS;
        end else if (!in_eop) begin
          state_d = S_DROP;
        end
      end
      S_PASS:  if (in_hs && (in_eop || in_sop)) state_d = S_IDLE;
      S_DROP:  if (in_hs && in_eop) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    fwd_dest = sel_q;
    fwd_sop  = in_sop;
    fwd_eop  = in_eop;
    drop_inc = 1'b0;
    err_inc  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!in_sop) begin
          in_ready = 1'b1;
          err_inc  = in_valid;
        end else if (chan_ok) begin
          fwd_dest = target;
          in_ready = slot_free[target];
        end else begin
          in_ready = 1'b1;
          drop_inc = in_valid;
        end
      end
      S_PASS: begin
        in_ready = slot_free[sel_q];
        // A SOP mid-packet closes the open packet on its own output.
        if (in_sop) begin
          fwd_sop = 1'b0;
          fwd_eop = 1'b1;
          err_inc = in_valid & in_ready;
        end
      end
      S_DROP:  in_ready = 1'b1;
      default: in_ready = 1'b0;
    endcase
    in_ready = in_ready & rst_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      if (drop_inc) drop_cnt_q <= drop_cnt_q + 32'd1;
      if (err_inc)  err_cnt_q  <= err_cnt_q + 32'd1;
    end
  end

  assign stats_drop_pkt = drop_cnt_q;
  assign stats_err_beat = err_cnt_q;

  for (genvar i = 0; i < N_OUT; i++) begin : g_out
    logic               load;
    logic               valid_r, sop_r, eop_r;
    logic [WIDTH-1:0]   data_r;
    logic [EMPTY_W-1:0] empty_r;
    logic [31:0]        pkt_cnt_r;

    assign load = fwd && (fwd_dest == SEL_W'(i));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)             valid_r <= 1'b0;
      else if (load)          valid_r <= 1'b1;
      else if (out_ready[i])  valid_r <= 1'b0;
    end

    // NOTE: payload flops carry no reset; they are only observed while valid_r is set.
    always_ff @(posedge clk) begin
      if (load) begin
        data_r  <= in_data;
        sop_r   <= fwd_sop;
        eop_r   <= fwd_eop;
        empty_r <= in_empty;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                              pkt_cnt_r <= '0;
      else if (valid_r && out_ready[i] && eop_r) pkt_cnt_r <= pkt_cnt_r + 32'd1;
    end

    assign out_valid[i]                    = valid_r;
    assign out_sop[i]                      = sop_r;
    assign out_eop[i]                      = eop_r;
    assign out_data[i*WIDTH +: WIDTH]      = data_r;
    assign out_empty[i*EMPTY_W +: EMPTY_W] = empty_r;
    assign stats_out_pkt[i*32 +: 32]       = pkt_cnt_r;
  end

endmodule

// File: tb/tb_pkt_steer_fork_avlstrm.sv
// Scoreboard bench for pkt_steer_fork_avlstrm: a packet-level model queues expected beats
// per output; a negedge monitor pops and compares every delivered beat.
module tb_pkt_steer_fork_avlstrm;
  localparam int WIDTH   = 512;
  localparam int EMPTY_W = 6;
  localparam int N_OUT   = 4;
  localparam int CHAN_W  = 8;

  typedef struct {
    logic [WIDTH-1:0]   data;
    bit                 sop;
    bit                 eop;
    logic [EMPTY_W-1:0] empty;
  } beat_t;

  typedef enum int {M_IDLE, M_PASS, M_DROP} mstate_t;

  logic                     clk, rst_n;
  logic [WIDTH-1:0]         in_data;
  logic                     in_valid, in_ready, in_sop, in_eop;
  logic [EMPTY_W-1:0]       in_empty;
  logic [CHAN_W-1:0]        in_channel;
  logic [N_OUT*WIDTH-1:0]   out_data;
  logic [N_OUT-1:0]         out_valid, out_ready, out_sop, out_eop;
  logic [N_OUT*EMPTY_W-1:0] out_empty;
  logic [N_OUT*32-1:0]      stats_out_pkt;
  logic [31:0]              stats_drop_pkt, stats_err_beat;

  pkt_steer_fork_avlstrm #(.WIDTH(WIDTH), .EMPTY_W(EMPTY_W), .N_OUT(N_OUT), .CHAN_W(CHAN_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop),
    .in_eop(in_eop), .in_empty(in_empty), .in_channel(in_channel),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_sop(out_sop),
    .out_eop(out_eop), .out_empty(out_empty),
    .stats_out_pkt(stats_out_pkt), .stats_drop_pkt(stats_drop_pkt), .stats_err_beat(stats_err_beat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec, n_err;
  int          cycle;
  always @(posedge clk) cycle++;

  // Reference model state
  beat_t      exp_q[N_OUT][$];
  int         exp_pkt[N_OUT];
  int         exp_drop, exp_err;
  mstate_t    m_state;
  int         m_sel;
  bit         lat_pending;
  int         lat_dest;
  beat_t      lat_beat;
  bit         held[N_OUT];
  beat_t      held_beat[N_OUT];
  logic [N_OUT-1:0] force_low;
  bit         rnd_ready;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] rand_data();
    logic [WIDTH-1:0] d;
    for (int k = 0; k < WIDTH/32; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic beat_t out_beat(input int i);
    beat_t b;
    b.data  = out_data[i*WIDTH +: WIDTH];
    b.sop   = out_sop[i];
    b.eop   = out_eop[i];
    b.empty = out_empty[i*EMPTY_W +: EMPTY_W];
    return b;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N_OUT; i++) begin
      exp_q[i].delete();
      exp_pkt[i] = 0;
      held[i]    = 1'b0;
    end
    exp_drop    = 0;
    exp_err     = 0;
    m_state     = M_IDLE;
    m_sel       = 0;
    lat_pending = 1'b0;
  endtask

  task automatic push(input int d, input beat_t b);
    exp_q[d].push_back(b);
    if (b.eop) exp_pkt[d]++;
    lat_pending = 1'b1;
    lat_dest    = d;
    lat_beat    = b;
  endtask

  // Packet-level behaviour: where does an accepted beat go and what does it look like
  task automatic model_accept(input beat_t b, input int ch);
    case (m_state)
      M_IDLE: begin
        if (!b.sop) exp_err++;
        else if (ch < N_OUT) begin
          push(ch, b);
          if (!b.eop) begin m_state = M_PASS; m_sel = ch; end
        end else begin
          exp_drop++;
          if (!b.eop) m_state = M_DROP;
        end
      end
      M_PASS: begin
        if (b.sop) begin
          b.sop = 1'b0;
          b.eop = 1'b1;
          exp_err++;
          push(m_sel, b);
          m_state = M_IDLE;
        end else begin
          push(m_sel, b);
          if (b.eop) m_state = M_IDLE;
        end
      end
      default: if (b.eop) m_state = M_IDLE;
    endcase
  endtask

  task automatic send_beat(input bit sop, input bit eop, input logic [CHAN_W-1:0] ch);
    beat_t b;
    bit    must_rdy, acc;
    int    waited;
    b.data   = rand_data();
    b.sop    = sop;
    b.eop    = eop;
    b.empty  = eop ? EMPTY_W'($urandom) : '0;
    must_rdy = (m_state == M_DROP) || (m_state == M_IDLE && (!sop || int'(ch) >= N_OUT));
    in_data = b.data; in_sop = sop; in_eop = eop; in_empty = b.empty; in_channel = ch;
    in_valid = 1'b1;
    acc = 1'b0;
    waited = 0;
    while (!acc) begin
      @(negedge clk);
      if (waited == 0 && must_rdy) check("ready_on_discard", in_ready, 1);
      if (in_ready) acc = 1'b1;
      else begin
        waited++;
        if (waited > 5000) begin
          n_vec++;
          n_err++;
          $display("FAIL accept_timeout: got in_ready=0 for %0d cycles expected accept", waited);
          in_valid = 1'b0;
          return;
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    model_accept(b, int'(ch));
  endtask

  task automatic send_pkt(input int ch, input int len, input bit inject = 1'b0);
    for (int b = 0; b < len; b++) begin
      bit sop;
      sop = (b == 0) || (inject && $urandom_range(0, 7) == 0);
      send_beat(sop, b == len - 1, (b == 0) ? CHAN_W'(ch) : CHAN_W'($urandom));
    end
  endtask

  function automatic bit any_pending();
    for (int i = 0; i < N_OUT; i++) if (exp_q[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drain_and_check(input string tag);
    int t;
    t = 0;
    while (any_pending() && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (any_pending()) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_drain: got beats still queued after %0d cycles expected empty", tag, t);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N_OUT; i++)
      check($sformatf("%s_out_pkt%0d", tag, i), stats_out_pkt[i*32 +: 32], exp_pkt[i]);
    check({tag, "_drop"}, stats_drop_pkt, exp_drop);
    check({tag, "_err"}, stats_err_beat, exp_err);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_out_pkt"}, stats_out_pkt, 0);
    check({tag, "_drop"}, stats_drop_pkt, 0);
    check({tag, "_err"}, stats_err_beat, 0);
  endtask

  // Monitor: scoreboard pops, 1-cycle latency and hold stability
  always @(negedge clk) begin
    beat_t b, e;
    if (rst_n) begin
      if (lat_pending) begin
        b = out_beat(lat_dest);
        check($sformatf("latency_valid%0d", lat_dest), out_valid[lat_dest], 1);
        check($sformatf("latency_data%0d", lat_dest), b.data, lat_beat.data);
        lat_pending = 1'b0;
      end
      for (int i = 0; i < N_OUT; i++) begin
        b = out_beat(i);
        if (held[i]) begin
          check($sformatf("hold_valid%0d", i), out_valid[i], 1);
          check($sformatf("hold_data%0d", i), b.data, held_beat[i].data);
          check($sformatf("hold_ctl%0d", i), {b.sop, b.eop}, {held_beat[i].sop, held_beat[i].eop});
        end
        if (out_valid[i] && out_ready[i]) begin
          if (exp_q[i].size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_beat%0d: got data %0h expected no beat", i, b.data);
          end else begin
            e = exp_q[i].pop_front();
            check($sformatf("beat_data%0d", i), b.data, e.data);
            check($sformatf("beat_sop_eop%0d", i), {b.sop, b.eop}, {e.sop, e.eop});
            if (e.eop) check($sformatf("beat_empty%0d", i), b.empty, e.empty);
          end
        end
        held[i]      = out_valid[i] && !out_ready[i];
        held_beat[i] = b;
      end
    end
  end

  initial begin
    out_ready = '1;
    forever begin
      @(posedge clk);
      #2;
      out_ready = (rnd_ready ? N_OUT'($urandom) : {N_OUT{1'b1}}) & ~force_low;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int c0;
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    in_data = '0; in_empty = '0; in_channel = '0;
    force_low = '0; rnd_ready = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // One 3-beat packet per output, all outputs ready
    for (int ch = 0; ch < N_OUT; ch++) send_pkt(ch, 3);
    drain_and_check("basic");

    // Output 2 stalled while its packet streams; ch1 packet follows
    force_low = 4'b0100;
    fork
      send_pkt(2, 5);
      begin
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid2", out_valid[2], 1);
        force_low = '0;
      end
    join
    send_pkt(1, 2);
    drain_and_check("stall");

    // Out-of-range channel is dropped whole
    send_pkt(7, 4);
    check("drop_no_valid", out_valid, 0);
    send_pkt(0, 2);
    drain_and_check("drop");

    // Stray non-SOP beat, then a SOP that cuts a ch1 packet short
    send_beat(1'b0, 1'b0, 8'd2);
    send_beat(1'b1, 1'b0, 8'd1);
    send_beat(1'b0, 1'b0, 8'd0);
    send_beat(1'b1, 1'b0, 8'd3);
    send_pkt(3, 2);
    drain_and_check("proto_err");

    // Back-to-back single-beat packets must sustain one beat per clock
    c0 = cycle;
    for (int k = 0; k < 20; k++) send_beat(1'b1, 1'b1, CHAN_W'(k % 2));
    check("single_beat_cycles", cycle - c0, 20);
    drain_and_check("single");

    // Random traffic with random backpressure and occasional protocol errors
    rnd_ready = 1'b1;
    for (int p = 0; p < 60; p++) begin
      if ($urandom_range(0, 9) == 0) send_beat(1'b0, 1'($urandom), CHAN_W'($urandom));
      send_pkt($urandom_range(0, 5), $urandom_range(1, 4), 1'b1);
    end
    drain_and_check("random");
    rnd_ready = 1'b0;

    // Reset in the middle of a packet
    send_beat(1'b1, 1'b0, 8'd2);
    send_beat(1'b0, 1'b0, 8'd0);
    rst_n = 1'b0;
    #1;
    check_reset_state("midreset");
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_pkt(2, 3);
    drain_and_check("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
